// File: rtl/mod_counter.sv
// mod_counter: parametrised synchronous modulo counter with clear, load and
// a combinational carry/borrow out for cascading stages.
//
// Optional feature macro: COUNTER_UPDOWN_EN
//   defined   -> an updown port selects the direction (1 = up, 0 = down)
//   undefined -> no updown port; the counter only counts up
//
// The count always stays inside 0..MODULUS-1. Loads of out-of-range values
// clamp to MODULUS-1. Terminal detection and the load range check are done
// at WIDTH+1 bits, so MODULUS = 2^WIDTH needs no special handling.

module mod_counter #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             cin,
  input  logic             sload,
  input  logic [WIDTH-1:0] data,
`ifdef COUNTER_UPDOWN_EN
  input  logic             updown,
`endif
  output logic [WIDTH-1:0] q,
  output logic             cout
);

  // Largest modulus the counter width can represent.
  localparam longint unsigned MOD_LIMIT = 64'd1 << WIDTH;

  // Modulus at WIDTH+1 bits; holds 2^WIDTH without overflow.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  // Highest legal count, also the clamp value for out-of-range loads.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  // Reject configurations the counter cannot implement.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH=%0d is outside 1..32", WIDTH);
  end
  if (MODULUS < 64'd2 || MODULUS > MOD_LIMIT) begin : g_bad_modulus
    $error("mod_counter: MODULUS=%0d is outside 2..2^WIDTH", MODULUS);
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] down_val;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;
  logic             count_up;
  logic             at_term;

  // Direction select; the up-only build behaves as updown tied high.
`ifdef COUNTER_UPDOWN_EN
  assign count_up = updown;
`else
  assign count_up = 1'b1;
`endif

  // Next-step values for both directions, wrap detection and load clamp.
  always_comb begin
    inc_ext  = {1'b0, q_q} + (WIDTH+1)'(1);
    up_val   = (inc_ext == MOD_EXT) ? '0 : inc_ext[WIDTH-1:0];
    down_val = (q_q == '0) ? MAX_VAL : q_q - WIDTH'(1);
    step_val = count_up ? up_val : down_val;
    at_term  = count_up ? (inc_ext == MOD_EXT) : (q_q == '0);
    load_val = ({1'b0, data} < MOD_EXT) ? data : MAX_VAL;
  end

  // Next-state selection: load beats count, count beats hold.
  always_comb begin
    // NOTE: defaulting q_d first keeps every path assigned, so no latch is inferred.
    q_d = q_q;
    if (sload) begin
      q_d = load_val;
    end else if (cin) begin
      q_d = step_val;
    end
  end

  // Count register with synchronous clear taking priority over everything.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (sclr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

  // Carry/borrow is high only in the cycle whose edge wraps the counter,
  // so it can feed the cin of the next stage directly.
  assign cout = cin & ~sclr & ~sload & at_term;

  // The stored count never leaves the legal range.
  a_q_in_range: assert property (@(posedge clock) ({1'b0, q_q} < MOD_EXT));

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised synchronous modulo counter, the next generation of the team's fixed 4-bit binary counter IP. It adds configurable width and modulus, synchronous clear and load, and an optional up/down mode. A combinational carry-out lets instances cascade into wider or multi-digit counters, such as BCD digit chains or timers. It sits wherever the design needs an event or cycle count driven by a single-cycle count-enable pulse.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (1..32)
- MODULUS, 16, count range 0..MODULUS-1; legal range 2..2^WIDTH

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- sclr  in  1  reset: synchronous and active-high; clears counter
- cin  in  1  count enable; one step per cycle while high
- sload  in  1  synchronous load of data
- data  in  WIDTH  load value
- updown  in  1  1 = count up, 0 = count down; present only with COUNTER_UPDOWN_EN
- q  out  WIDTH  current count (registered)
- cout  out  1  carry/borrow out (combinational)

## Operation
- Priority at each rising clock edge: sclr, then sload, then cin, then hold.
- sclr=1: q <= 0.
- sload=1 and sclr=0: q <= data if data < MODULUS, else q <= MODULUS-1 (clamp; an out-of-range value is never stored).
- cin=1, up direction: q <= 0 if q == MODULUS-1, else q+1.
- cin=1, down direction: q <= MODULUS-1 if q == 0, else q-1.
- cin=0: q holds.
- Terminal value: MODULUS-1 when counting up, 0 when counting down.
- cout = cin & ~sclr & ~sload & (q == terminal). It is high exactly in the cycle whose edge wraps the counter, so it can drive the cin of the next stage directly.
- Arithmetic is performed at WIDTH+1 bits internally. When MODULUS = 2^WIDTH there is no overflow and the counter wraps naturally.
- Direction changes take effect on the same edge; there is no pipeline.
- Illegal MODULUS (< 2 or > 2^WIDTH) must stop elaboration with an error.

## Timing
- Reset values: q = 0. cout = 0 while sclr=1.
- Latency: q reflects sclr, sload or a count step one clock after the input is sampled high.
- cout is combinational from cin, sclr, sload, q and updown, with zero-cycle latency. A cascade of N stages adds N AND-levels to the path.
- Simultaneous sload and cin: the load wins, no count step occurs, and cout = 0.
- Simultaneous sclr with anything: the clear wins.
- If sclr is asserted mid-count, q is 0 on the next edge regardless of direction or load.
- After sclr deasserts, the first cin step produces q = 1 (up) or q = MODULUS-1 (down).

## Configuration
- COUNTER_UPDOWN_EN defined: the updown port exists, and both directions and the direction-dependent terminal value are implemented.
- COUNTER_UPDOWN_EN undefined: there is no updown port, the counter is up-only, and the terminal value is always MODULUS-1. Behaviour is identical to the defined build with updown tied to 1.

## Test plan
- WIDTH=4, MODULUS=10, up: sclr for 2 cycles, then cin=1 for 12 cycles -> q goes 0,1,…,9,0,1,2; cout=1 only in the cycle with q=9.
- WIDTH=4, MODULUS=16: pulse cin high for 1 cycle every other cycle, 20 pulses -> q=4 at the end; exactly one cout pulse, at q=15 with cin=1.
- Load: data=7 with sload=1 and cin=1 together -> q=7 next cycle, cout=0. Then data=12 with MODULUS=10 -> q=9.
- COUNTER_UPDOWN_EN, MODULUS=10: load 2, updown=0, cin=1 for 4 cycles -> q goes 1,0,9,8; cout=1 only in the cycle with q=0. Toggle updown=1 at q=8 -> next q=9.
- Cascade: two instances with MODULUS=10, stage-0 cout driving stage-1 cin, cin=1 for 25 cycles from clear -> {q1,q0} = {2,5}.
- Reset mid-operation: at q=6 with cin=1 and sload=1, assert sclr -> q=0 next cycle and cout=0 during the sclr cycle.
